float_add_arbiter: RTL and testbench

- Shares one pipelined float adder (fixed latency, one issue per clock, no stall, no reset) among NUM_PORTS requesters.
- Each requester port has:
  - a valid/ready request channel carrying operands A and B;
  - a valid/ready response channel carrying the sum.
- Sits between client engines (accumulators, dot-product sequencers) and the adder instance. Drives the adder's operand inputs and captures its sum output.
- Tracks ownership of in-flight operations with a tag pipeline. Guarantees by credit that no result is ever dropped.

---
 rtl/float_add_arbiter.sv | 174 +++++++++++++++++
 tb/tb_float_add_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_add_arbiter.sv
// float_add_arbiter: shares one fixed-latency pipelined float adder among
// NUM_PORTS requesters. A round-robin arbiter issues at most one operation
// per clock. A tag pipe that runs alongside the adder routes each sum back
// to its owner's response FIFO. Per-port credits count in-flight operations
// plus FIFO occupancy, so a FIFO can never overflow.
// Optional build macro FLOAT_ADD_ARB_SUB_EN adds a per-port reqSub input.
// When the granted port's reqSub bit is set, the sign of B is flipped and
// the port receives A-B.
module float_add_arbiter #(
  parameter  int MANTISSA_SIZE = 23,
  parameter  int EXPONENT_SIZE = 8,
  parameter  int NUM_PORTS     = 4,
  parameter  int ADD_LATENCY   = 4,
  parameter  int RSP_DEPTH     = 4,
  localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS-1:0]            reqValid,
  output logic [NUM_PORTS-1:0]            reqReady,
  input  logic [NUM_PORTS*FLOAT_SIZE-1:0] reqA,
  input  logic [NUM_PORTS*FLOAT_SIZE-1:0] reqB,
`ifdef FLOAT_ADD_ARB_SUB_EN
  input  logic [NUM_PORTS-1:0]            reqSub,
`endif
  output logic [NUM_PORTS-1:0]            rspValid,
  input  logic [NUM_PORTS-1:0]            rspReady,
  output logic [NUM_PORTS*FLOAT_SIZE-1:0] rspSum,
  output logic [FLOAT_SIZE-1:0]           addA,
  output logic [FLOAT_SIZE-1:0]           addB,
  input  logic [FLOAT_SIZE-1:0]           addSum
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int AW = $clog2(RSP_DEPTH);

  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  grant;
  logic [NUM_PORTS-1:0]  wr_en;
  logic [NUM_PORTS-1:0]  pop;
  logic                  grant_any;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [FLOAT_SIZE-1:0] add_a_q, add_a_d;
  logic [FLOAT_SIZE-1:0] add_b_q, add_b_d;
  logic [FLOAT_SIZE-1:0] b_sel;
  logic [ADD_LATENCY:0]  tag_vld_q, tag_vld_d;
  logic [PW-1:0]         tag_q [ADD_LATENCY+1];
  logic [PW-1:0]         tag_d [ADD_LATENCY+1];

  // Round-robin scan: the first eligible port at or above the pointer wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Pointer moves just past the winner; it holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Operand mux: capture the winner's operands. The registers hold when idle.
  always_comb begin
    b_sel = reqB[int'(grant_idx)*FLOAT_SIZE +: FLOAT_SIZE];
`ifdef FLOAT_ADD_ARB_SUB_EN
    b_sel[FLOAT_SIZE-1] = b_sel[FLOAT_SIZE-1] ^ reqSub[grant_idx];
`endif
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (grant_any) begin
      add_a_d = reqA[int'(grant_idx)*FLOAT_SIZE +: FLOAT_SIZE];
      add_b_d = b_sel;
    end
  end

  // Tag pipe: stage 0 is loaded with the operands. Stage ADD_LATENCY lines up with addSum.
  always_comb begin
    tag_vld_d[0] = grant_any;
    tag_d[0]     = grant_idx;
    for (int s = 1; s <= ADD_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_d[s]     = tag_q[s-1];
    end
  end

  // Shared state registers: pointer, operand registers and tag pipe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s <= ADD_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      tag_vld_q <= tag_vld_d;
      for (int s = 0; s <= ADD_LATENCY; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign reqReady = grant;
  assign addA     = add_a_q;
  assign addB     = add_b_q;

  // Per-port credit counter and response FIFO.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [FLOAT_SIZE-1:0] mem_q [RSP_DEPTH];
      logic [CW-1:0]         credit_q, credit_d;
      logic [CW-1:0]         count_q, count_d;
      logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]         rd_ptr_q, rd_ptr_d;

      // Eligibility is gated by resetn so that no grant is offered during reset.
      assign eligible[gi] = resetn && reqValid[gi] && (credit_q < CW'(RSP_DEPTH));
      assign wr_en[gi]    = tag_vld_q[ADD_LATENCY] && (tag_q[ADD_LATENCY] == PW'(gi));
      assign pop[gi]      = rspValid[gi] && rspReady[gi];

      // Credit and FIFO bookkeeping. A simultaneous increment and decrement cancel out.
      always_comb begin
        credit_d = credit_q;
        if (grant[gi] && !pop[gi]) credit_d = credit_q + 1'b1;
        else if (!grant[gi] && pop[gi]) credit_d = credit_q - 1'b1;
        count_d = count_q;
        if (wr_en[gi] && !pop[gi]) count_d = count_q + 1'b1;
        else if (!wr_en[gi] && pop[gi]) count_d = count_q - 1'b1;
        wr_ptr_d = wr_en[gi] ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop[gi] ? rd_ptr_q + 1'b1 : rd_ptr_q;
      end

      // Control registers for this port.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          credit_q <= '0;
          count_q  <= '0;
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          credit_q <= credit_d;
          count_q  <= count_d;
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      end

      // FIFO storage. It has no reset because an empty count masks stale entries.
      always_ff @(posedge clk) begin
        if (wr_en[gi]) mem_q[wr_ptr_q] <= addSum;
      end

      assign rspValid[gi]                           = (count_q != '0);
      assign rspSum[gi*FLOAT_SIZE +: FLOAT_SIZE]    = mem_q[rd_ptr_q];
    end
  endgenerate

endmodule

// File: tb/tb_float_add_arbiter.sv
// Testbench for float_add_arbiter. A behavioural 4-cycle float adder drives addSum.
// Operands are small random integers encoded as floats, so every sum is exact.
module tb_float_add_arbiter;
  localparam int FS    = 32;
  localparam int NP    = 4;
  localparam int LAT   = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NP-1:0]     reqValid, reqReady, rspValid, rspReady;
  logic [NP*FS-1:0]  reqA, reqB, rspSum;
  logic [FS-1:0]     addA, addB, addSum;
`ifdef FLOAT_ADD_ARB_SUB_EN
  logic [NP-1:0]     reqSub;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] exp_q [NP][$];
  logic [31:0] got_q [NP][$];
  int          grant_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  float_add_arbiter dut (
    .clk(clk), .resetn(resetn),
    .reqValid(reqValid), .reqReady(reqReady), .reqA(reqA), .reqB(reqB),
`ifdef FLOAT_ADD_ARB_SUB_EN
    .reqSub(reqSub),
`endif
    .rspValid(rspValid), .rspReady(rspReady), .rspSum(rspSum),
    .addA(addA), .addB(addB), .addSum(addSum)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_f();
    return r2f($itor($urandom_range(0, 1000)));
  endfunction

  // Adder environment model: the sum appears LAT clocks after addA/addB are sampled.
  logic [FS-1:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= r2f(f2r(addA) + f2r(addB));
    for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
  end
  assign addSum = apipe[LAT-1];

  // Transaction monitor: on each handshake, push the mathematically expected
  // result; on each pop, push the observed result.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      for (int p = 0; p < NP; p++) begin
        if (reqValid[p] && reqReady[p]) begin
          logic sub;
          real  rb;
`ifdef FLOAT_ADD_ARB_SUB_EN
          sub = reqSub[p];
`else
          sub = 1'b0;
`endif
          rb = f2r(reqB[p*FS +: FS]);
          if (sub) rb = -rb;
          exp_q[p].push_back(r2f(f2r(reqA[p*FS +: FS]) + rb));
          grant_q.push_back(p);
          $display("cyc %0d req  port %0d A=%h B=%h sub=%0d", cyc, p, reqA[p*FS +: FS], reqB[p*FS +: FS], sub);
        end
        if (rspValid[p] && rspReady[p]) begin
          got_q[p].push_back(rspSum[p*FS +: FS]);
          $display("cyc %0d rsp  port %0d sum=%h", cyc, p, rspSum[p*FS +: FS]);
        end
      end
    end
  end

  task automatic clear_sb();
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      got_q[p].delete();
    end
    grant_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reqValid = '0; rspReady = '0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    clear_sb();
  endtask

  // Waits until every accepted request has been popped, or until the cycle budget runs out.
  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = (rspValid == '0);
      for (int p = 0; p < NP; p++)
        if (got_q[p].size() != exp_q[p].size()) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; reqValid = '1; rspReady = '1;
    for (int p = 0; p < NP; p++) begin
      reqA[p*FS +: FS] = rnd_f();
      reqB[p*FS +: FS] = rnd_f();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (reqReady !== 4'b0000) begin errors++; $display("FAIL reset_reqReady got %b want 0000", reqReady); end
    checks++; if (rspValid !== 4'b0000) begin errors++; $display("FAIL reset_rspValid got %b want 0000", rspValid); end
    checks++; if (addA !== 32'h0) begin errors++; $display("FAIL reset_addA got %h want 0", addA); end
    checks++; if (addB !== 32'h0) begin errors++; $display("FAIL reset_addB got %h want 0", addB); end
    @(posedge clk); #1;
    resetn = 1'b1; reqValid = '0; rspReady = '0;
    clear_sb();
  endtask

  task automatic test_single();
    int c, seen;
    @(posedge clk); #1;
    reqA[0 +: FS] = 32'h3F800000; reqB[0 +: FS] = 32'h40000000; reqValid = 4'b0001;
    @(negedge clk);
    c = cyc;
    checks++; if (reqReady !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", reqReady); end
    @(posedge clk); #1;
    reqValid = '0;
    seen = -1;
    for (int k = 0; k < 20 && seen < 0; k++) begin
      @(negedge clk);
      if (rspValid != 4'b0000) seen = cyc;
    end
    checks++; if (seen !== c + 6) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", seen, c + 6); end
    checks++; if (rspValid !== 4'b0001) begin errors++; $display("FAIL single_rspValid got %b want 0001", rspValid); end
    checks++; if (rspSum[0 +: FS] !== 32'h40400000) begin errors++; $display("FAIL single_sum got %h want 40400000", rspSum[0 +: FS]); end
    @(posedge clk); #1; rspReady = 4'b0001;
    @(posedge clk); #1; rspReady = 4'b0000;
    @(negedge clk);
    checks++; if (rspValid !== 4'b0000) begin errors++; $display("FAIL single_pop got %b want 0000", rspValid); end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    rspReady = '1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      reqValid = '1;
      for (int p = 0; p < NP; p++) begin
        reqA[p*FS +: FS] = rnd_f();
        reqB[p*FS +: FS] = rnd_f();
      end
`ifdef FLOAT_ADD_ARB_SUB_EN
      reqSub = 4'($urandom_range(0, 15));
`endif
    end
    @(posedge clk); #1;
    reqValid = '0;
    checks++; if (grant_q.size() !== 12) begin errors++; $display("FAIL rr_grant_count got %0d want 12", grant_q.size()); end
    for (int k = 0; k < 12 && k < grant_q.size(); k++) begin
      checks++; if (grant_q[k] !== k % NP) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", k, grant_q[k], k % NP); end
    end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_drain got timeout want all responses"); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (got_q[p].size() !== exp_q[p].size()) begin errors++; $display("FAIL rr_rsp_count port %0d got %0d want %0d", p, got_q[p].size(), exp_q[p].size()); end
      else for (int k = 0; k < exp_q[p].size(); k++) begin
        checks++; if (got_q[p][k] !== exp_q[p][k]) begin errors++; $display("FAIL rr_sum port %0d #%0d got %h want %h", p, k, got_q[p][k], exp_q[p][k]); end
      end
    end
`ifdef FLOAT_ADD_ARB_SUB_EN
    reqSub = '0;
`endif
  endtask

  task automatic test_credit();
    int  acc, leaked;
    bit  ok;
    apply_reset();
    acc = 0; leaked = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      reqValid = 4'b0100;
      reqA[2*FS +: FS] = rnd_f(); reqB[2*FS +: FS] = rnd_f();
      @(negedge clk);
      if (reqReady[2]) acc++;
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL credit_accepts got %0d want 4", acc); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      reqA[2*FS +: FS] = rnd_f();
      @(negedge clk);
      if (reqReady[2]) leaked++;
    end
    checks++; if (leaked !== 0) begin errors++; $display("FAIL credit_block got %0d extra grants want 0", leaked); end
    checks++; if (rspValid !== 4'b0100) begin errors++; $display("FAIL credit_rspValid got %b want 0100", rspValid); end
    @(posedge clk); #1; rspReady = 4'b0100;
    @(negedge clk);
    checks++; if (reqReady[2] !== 1'b0) begin errors++; $display("FAIL credit_pop_cycle got %b want 0", reqReady[2]); end
    @(posedge clk); #1; rspReady = 4'b0000;
    @(negedge clk);
    checks++; if (reqReady[2] !== 1'b1) begin errors++; $display("FAIL credit_after_pop got %b want 1", reqReady[2]); end
    @(posedge clk); #1;
    reqValid = '0; rspReady = 4'b0100;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL credit_drain got timeout want all responses"); end
    // One response was popped before the final drain. It was already in got_q, so the total is 5.
    checks++; if (got_q[2].size() !== 5 || exp_q[2].size() !== 5) begin errors++; $display("FAIL credit_total got %0d/%0d want 5/5", got_q[2].size(), exp_q[2].size()); end
    for (int k = 0; k < 5 && k < got_q[2].size() && k < exp_q[2].size(); k++) begin
      checks++; if (got_q[2][k] !== exp_q[2][k]) begin errors++; $display("FAIL credit_sum #%0d got %h want %h", k, got_q[2][k], exp_q[2][k]); end
    end
    rspReady = '0;
  endtask

  task automatic test_priority();
    bit ok;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      reqValid = (k < 4) ? 4'b0010 : 4'b0001;
      for (int p = 0; p < NP; p++) begin
        reqA[p*FS +: FS] = rnd_f();
        reqB[p*FS +: FS] = rnd_f();
      end
    end
    @(posedge clk); #1;
    reqValid = 4'b1010;
    @(negedge clk);
    checks++; if (reqReady !== 4'b1000) begin errors++; $display("FAIL priority_skip_full got %b want 1000", reqReady); end
    @(posedge clk); #1;
    reqValid = '0; rspReady = '1;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL priority_drain got timeout want all responses"); end
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < exp_q[p].size() && k < got_q[p].size(); k++) begin
        checks++; if (got_q[p][k] !== exp_q[p][k]) begin errors++; $display("FAIL priority_sum port %0d #%0d got %h want %h", p, k, got_q[p][k], exp_q[p][k]); end
      end
    end
    rspReady = '0;
  endtask

  task automatic test_reset_midflight();
    int c, seen;
    apply_reset();
    rspReady = '1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      reqValid = 4'b0111;
      for (int p = 0; p < NP; p++) begin
        reqA[p*FS +: FS] = rnd_f();
        reqB[p*FS +: FS] = rnd_f();
      end
    end
    @(posedge clk); #1;
    reqValid = '0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    clear_sb();
    reqA[1*FS +: FS] = 32'h40A00000; reqB[1*FS +: FS] = 32'h40E00000; reqValid = 4'b0010;
    @(negedge clk);
    c = cyc;
    checks++; if (reqReady !== 4'b0010) begin errors++; $display("FAIL midreset_grant got %b want 0010", reqReady); end
    @(posedge clk); #1;
    reqValid = '0; rspReady = '0;
    seen = -1;
    for (int k = 0; k < 20 && seen < 0; k++) begin
      @(negedge clk);
      if (rspValid != 4'b0000) seen = cyc;
    end
    checks++; if (seen !== c + 6) begin errors++; $display("FAIL midreset_first_rsp got cycle %0d want %0d", seen, c + 6); end
    checks++; if (rspValid !== 4'b0010) begin errors++; $display("FAIL midreset_rspValid got %b want 0010", rspValid); end
    checks++; if (rspSum[1*FS +: FS] !== 32'h41400000) begin errors++; $display("FAIL midreset_sum got %h want 41400000", rspSum[1*FS +: FS]); end
    @(posedge clk); #1; rspReady = 4'b0010;
    @(posedge clk); #1; rspReady = 4'b0000;
  endtask

`ifdef FLOAT_ADD_ARB_SUB_EN
  task automatic test_sub();
    int seen;
    apply_reset();
    @(posedge clk); #1;
    reqA[3*FS +: FS] = 32'h40400000; reqB[3*FS +: FS] = 32'h3F800000;
    reqSub = 4'b1000; reqValid = 4'b1000;
    @(posedge clk); #1;
    reqValid = '0; reqSub = '0;
    seen = -1;
    for (int k = 0; k < 20 && seen < 0; k++) begin
      @(negedge clk);
      if (rspValid[3]) seen = cyc;
    end
    checks++; if (seen < 0) begin errors++; $display("FAIL sub_timeout got none want rspValid[3]"); end
    checks++; if (rspSum[3*FS +: FS] !== 32'h40000000) begin errors++; $display("FAIL sub_sum got %h want 40000000", rspSum[3*FS +: FS]); end
  endtask
`endif

  initial begin
    reqValid = '0; rspReady = '0; reqA = '0; reqB = '0; resetn = 1'b0;
`ifdef FLOAT_ADD_ARB_SUB_EN
    reqSub = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_credit();
    test_priority();
    test_reset_midflight();
`ifdef FLOAT_ADD_ARB_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
